// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-requester arbiter with bounded lock, tagged read return and ROM write flag
module mem_arbiter #(
   parameter int READ_LATENCY = 1,
   parameter int MAX_LOCK     = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [15:0] addr0,
   input  logic [15:0] addr1,
   input  logic [15:0] wdata0,
   input  logic [15:0] wdata1,
   input  logic        lock0,
   input  logic        lock1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [15:0] rdata0,
   output logic [15:0] rdata1,
   output logic        rom_wr_err,
   output logic [15:0] read_address,
   output logic [15:0] write_address,
   output logic [15:0] write_data,
   output logic        write_enable,
   input  logic [15:0] read_data
);
   localparam logic [3:0] LOCK_MAX = 4'(MAX_LOCK);
   logic                    r_last, r_lock_valid;
   logic [3:0]              r_lock_cnt;
   logic [READ_LATENCY-1:0] r_pv, r_pid;
   logic                    w_any, w_id, w_we, w_locked, w_other_req;
   logic                    w_tail_v, w_tail_id;
   always_comb begin
      w_locked    = r_lock_valid && r_lock_cnt < LOCK_MAX && (r_last ? req1 : req0);
      w_other_req = r_last ? req0 : req1;
      w_any       = !reset && (req0 || req1);
      w_id        = w_locked ? r_last : (req0 && req1) ? !r_last : !req0;
      w_we        = w_id ? we1 : we0;
   end
   assign gnt0          = w_any && !w_id;
   assign gnt1          = w_any && w_id;
   // idle cycles park the buses on requester 0
   assign read_address  = gnt1 ? addr1 : addr0;
   assign write_address = read_address;
   assign write_data    = gnt1 ? wdata1 : wdata0;
   assign write_enable  = w_any && w_we;
   assign w_tail_v      = r_pv[READ_LATENCY-1];
   assign w_tail_id     = r_pid[READ_LATENCY-1];
   always_ff @(posedge clock) begin
      if (reset) begin
         r_last       <= 1'b1;
         r_lock_valid <= 1'b0;
         r_lock_cnt   <= '0;
         r_pv         <= '0;
         r_pid        <= '0;
         rvalid0      <= 1'b0;
         rvalid1      <= 1'b0;
         rdata0       <= '0;
         rdata1       <= '0;
         rom_wr_err   <= 1'b0;
      end else begin
         r_last       <= w_any ? w_id : r_last;
         r_lock_valid <= w_any && (w_id ? lock1 : lock0);
         // only contended locked re-grants consume the lock budget
         r_lock_cnt   <= (!w_any || w_id != r_last) ? 4'd0 :
                         (w_locked && w_other_req) ? r_lock_cnt + 4'd1 : r_lock_cnt;
         r_pv[0]      <= w_any && !w_we;
         r_pid[0]     <= w_id;
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_pv[i]  <= r_pv[i-1];
            r_pid[i] <= r_pid[i-1];
         end
         rvalid0      <= w_tail_v && !w_tail_id;
         rvalid1      <= w_tail_v && w_tail_id;
         rdata0       <= (w_tail_v && !w_tail_id) ? read_data : rdata0;
         rdata1       <= (w_tail_v && w_tail_id) ? read_data : rdata1;
         rom_wr_err   <= w_any && w_we && !read_address[15];
      end
   end
endmodule
